// File: rtl/rs_param_station.sv
// ALU reservation station: DEPTH entries, CDB wakeup/capture, registered issue port, flush.
// Define RS_OLDEST_FIRST_EN to issue the oldest ready entry (age matrix) instead of the lowest index.
module rs_param_station #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TAG_BASE = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [4:0]        disp_op,
  input  logic [31:0]       disp_addr,
  input  logic [31:0]       disp_vj,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic [31:0]       disp_vk,
  input  logic [TAG_W-1:0]  disp_qk,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cdb_active,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_val,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [TAG_W-1:0]  iss_tag,
  output logic [4:0]        iss_op,
  output logic [31:0]       iss_vj,
  output logic [31:0]       iss_vk,
  output logic [31:0]       iss_addr,
  output logic [3:0]        occupancy
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OCC_W  = 4;

  logic [DEPTH-1:0]  busy;
  logic [OP_W-1:0]   e_op   [DEPTH];
  logic [DATA_W-1:0] e_addr [DEPTH];
  logic [DATA_W-1:0] e_vj   [DEPTH];
  logic [DATA_W-1:0] e_vk   [DEPTH];
  logic [TAG_W-1:0]  e_qj   [DEPTH];
  logic [TAG_W-1:0]  e_qk   [DEPTH];

  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  busy_nxt;
  logic [OCC_W-1:0]  occ_nxt;
  logic [IDX_W-1:0]  free_idx;
  logic              free_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic              advance;
  logic              disp_fire;
  logic              iss_fire;
  logic              cap_j;
  logic              cap_k;

  // Lowest-index free entry receives the next dispatch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_found;
  assign disp_tag   = free_found ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;

  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready_vec[i] = busy[i] && (e_qj[i] == '0) && (e_qk[i] == '0);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // age[j][i] = 1 means entry j was dispatched before entry i.
  logic [DEPTH-1:0] age [DEPTH];
  logic [DEPTH-1:0] has_older;

  always_comb begin
    has_older = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready_vec[j] && age[j][i]) begin
          has_older[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ready_vec[i] && !has_older[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          age[i] <= '0;
        end
      end else if (disp_fire) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          age[j][free_idx] <= (IDX_W'(j) != free_idx) && busy[j];
        end
        age[free_idx] <= '0;
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ready_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  assign advance   = rdy_in && !flush_in;
  assign disp_fire = disp_valid && free_found && advance;
  assign iss_fire  = advance && (!iss_valid || iss_ready) && sel_found;
  assign cap_j     = cdb_active && (disp_qj != '0) && (cdb_tag == disp_qj);
  assign cap_k     = cdb_active && (disp_qk != '0) && (cdb_tag == disp_qk);

  always_comb begin
    busy_nxt = busy;
    if (rdy_in) begin
      if (flush_in) begin
        busy_nxt = '0;
      end else begin
        if (iss_fire)  busy_nxt[sel_idx]  = 1'b0;
        if (disp_fire) busy_nxt[free_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    occ_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OCC_W'(busy_nxt[i]);
    end
  end

  // Entry storage: wakeup of waiting operands, then the dispatch write into the free slot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy      <= '0;
      occupancy <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_op[i]   <= '0;
        e_addr[i] <= '0;
        e_vj[i]   <= '0;
        e_vk[i]   <= '0;
        e_qj[i]   <= '0;
        e_qk[i]   <= '0;
      end
    end else if (rdy_in) begin
      busy      <= busy_nxt;
      occupancy <= occ_nxt;
      if (!flush_in) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (cdb_active && busy[i] && (e_qj[i] != '0) && (e_qj[i] == cdb_tag)) begin
            e_vj[i] <= cdb_val;
            e_qj[i] <= '0;
          end
          if (cdb_active && busy[i] && (e_qk[i] != '0) && (e_qk[i] == cdb_tag)) begin
            e_vk[i] <= cdb_val;
            e_qk[i] <= '0;
          end
        end
        if (disp_fire) begin
          e_op[free_idx]   <= disp_op;
          e_addr[free_idx] <= disp_addr;
          e_vj[free_idx]   <= cap_j ? cdb_val : disp_vj;
          e_qj[free_idx]   <= cap_j ? '0 : disp_qj;
          e_vk[free_idx]   <= cap_k ? cdb_val : disp_vk;
          e_qk[free_idx]   <= cap_k ? '0 : disp_qk;
        end
      end
    end
  end

  // Issue register: holds while stalled, drops when drained with nothing ready.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      iss_valid <= 1'b0;
      iss_tag   <= '0;
      iss_op    <= '0;
      iss_vj    <= '0;
      iss_vk    <= '0;
      iss_addr  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        iss_valid <= 1'b0;
      end else if (iss_fire) begin
        iss_valid <= 1'b1;
        iss_tag   <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
        iss_op    <= e_op[sel_idx];
        iss_vj    <= e_vj[sel_idx];
        iss_vk    <= e_vk[sel_idx];
        iss_addr  <= e_addr[sel_idx];
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_param_station.sv
// Self-checking bench for rs_param_station; issue order follows RS_OLDEST_FIRST_EN when defined.
module tb_rs_param_station;

  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4:0]       op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      addr;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              flush_in;
  logic              disp_valid;
  logic              disp_ready;
  logic [4:0]        disp_op;
  logic [31:0]       disp_addr;
  logic [31:0]       disp_vj;
  logic [TAG_W-1:0]  disp_qj;
  logic [31:0]       disp_vk;
  logic [TAG_W-1:0]  disp_qk;
  logic [TAG_W-1:0]  disp_tag;
  logic              cdb_active;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_val;
  logic              iss_valid;
  logic              iss_ready;
  logic [TAG_W-1:0]  iss_tag;
  logic [4:0]        iss_op;
  logic [31:0]       iss_vj;
  logic [31:0]       iss_vk;
  logic [31:0]       iss_addr;
  logic [3:0]        occupancy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb [$];
  exp_t mon_exp;

  always #5 clk_in = ~clk_in;

  rs_param_station #(.DEPTH(4), .TAG_W(TAG_W), .TAG_BASE(1)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_op    (disp_op),
    .disp_addr  (disp_addr),
    .disp_vj    (disp_vj),
    .disp_qj    (disp_qj),
    .disp_vk    (disp_vk),
    .disp_qk    (disp_qk),
    .disp_tag   (disp_tag),
    .cdb_active (cdb_active),
    .cdb_tag    (cdb_tag),
    .cdb_val    (cdb_val),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_tag    (iss_tag),
    .iss_op     (iss_op),
    .iss_vj     (iss_vj),
    .iss_vk     (iss_vk),
    .iss_addr   (iss_addr),
    .occupancy  (occupancy)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int tag, input int op, input logic [31:0] vj,
                                  input logic [31:0] vk, input logic [31:0] addr);
    exp_t e;
    e.tag  = TAG_W'(tag);
    e.op   = 5'(op);
    e.vj   = vj;
    e.vk   = vk;
    e.addr = addr;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_disp(input int op, input logic [31:0] addr, input logic [31:0] vj,
                          input int qj, input logic [31:0] vk, input int qk);
    disp_valid = 1'b1;
    disp_op    = 5'(op);
    disp_addr  = addr;
    disp_vj    = vj;
    disp_qj    = TAG_W'(qj);
    disp_vk    = vk;
    disp_qk    = TAG_W'(qk);
  endtask

  task automatic set_cdb(input int tag, input logic [31:0] val);
    cdb_active = 1'b1;
    cdb_tag    = TAG_W'(tag);
    cdb_val    = val;
  endtask

  // Every accepted issue transfer is compared against the head of the scoreboard.
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && !flush_in && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra_issue_tag", 32'(iss_tag), 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_tag",  32'(iss_tag), 32'(mon_exp.tag));
        check("sb_op",   32'(iss_op),  32'(mon_exp.op));
        check("sb_vj",   iss_vj,       mon_exp.vj);
        check("sb_vk",   iss_vk,       mon_exp.vk);
        check("sb_addr", iss_addr,     mon_exp.addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; iss_ready = 1'b0;
    disp_valid = 1'b0; disp_op = '0; disp_addr = '0; disp_vj = '0; disp_qj = '0;
    disp_vk = '0; disp_qk = '0; cdb_active = 1'b0; cdb_tag = '0; cdb_val = '0;
    repeat (2) cyc();
    check("rst_iss_valid",  32'(iss_valid),  32'd0);
    check("rst_occupancy",  32'(occupancy),  32'd0);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_disp_tag",   32'(disp_tag),   32'd1);
    check("rst_iss_vj",     iss_vj,          32'd0);
    rst_in = 1'b1;
    cyc();

    // Ready operands: issue one edge after dispatch.
    iss_ready = 1'b1;
    set_disp(0, 32'h100, 32'd5, 0, 32'd7, 0);
    check("t1_disp_tag", 32'(disp_tag), 32'd1);
    sb.push_back(mk_exp(1, 0, 32'd5, 32'd7, 32'h100));
    cyc();
    disp_valid = 1'b0;
    check("t1_not_yet",  32'(iss_valid), 32'd0);
    check("t1_occ1",     32'(occupancy), 32'd1);
    cyc();
    check("t1_iss_valid", 32'(iss_valid), 32'd1);
    check("t1_occ0",      32'(occupancy), 32'd0);
    cyc();
    check("t1_drop", 32'(iss_valid), 32'd0);

    // Same-cycle CDB capture at dispatch.
    set_cdb(3, 32'h10);
    set_disp(1, 32'h104, 32'hdead, 3, 32'd2, 0);
    sb.push_back(mk_exp(1, 1, 32'h10, 32'd2, 32'h104));
    cyc();
    disp_valid = 1'b0; cdb_active = 1'b0;
    check("t2_occ1", 32'(occupancy), 32'd1);
    cyc();
    check("t2_iss_valid", 32'(iss_valid), 32'd1);
    check("t2_iss_vj",    iss_vj,          32'h10);
    cyc();

    // Fill all entries waiting on tag 9, then one broadcast drains them.
    for (int i = 0; i < 4; i++) begin
      set_disp(i + 2, 32'h200 + 32'(4 * i), 32'd0, 9, 32'(20 + i), 0);
      check("t3_disp_tag", 32'(disp_tag), 32'(i + 1));
      sb.push_back(mk_exp(i + 1, i + 2, 32'd1, 32'(20 + i), 32'h200 + 32'(4 * i)));
      cyc();
    end
    set_disp(31, 32'hbad, 32'hbad, 0, 32'hbad, 0);
    check("t3_full_ready", 32'(disp_ready), 32'd0);
    check("t3_full_tag",   32'(disp_tag),   32'd0);
    check("t3_full_occ",   32'(occupancy),  32'd4);
    cyc();
    disp_valid = 1'b0;
    check("t3_no_overwrite_occ", 32'(occupancy), 32'd4);
    check("t3_none_ready",       32'(iss_valid), 32'd0);
    set_cdb(9, 32'd1);
    cyc();
    cdb_active = 1'b0;
    check("t3_wake_edge", 32'(iss_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("t3_iss_valid", 32'(iss_valid), 32'd1);
      check("t3_iss_tag",   32'(iss_tag),   32'(k + 1));
      check("t3_occ",       32'(occupancy), 32'(3 - k));
    end
    cyc();
    check("t3_drained", 32'(iss_valid), 32'd0);

    // Global enable low freezes everything.
    rdy_in = 1'b0;
    set_disp(3, 32'h300, 32'd1, 0, 32'd2, 0);
    cyc();
    check("t5_frozen_occ", 32'(occupancy), 32'd0);
    check("t5_frozen_tag", 32'(disp_tag),  32'd1);
    cyc();
    check("t5_frozen_iss", 32'(iss_valid), 32'd0);
    disp_valid = 1'b0;
    rdy_in = 1'b1;

    // Stall holds the issue register; flush kills it and the waiting entry.
    iss_ready = 1'b0;
    set_disp(7, 32'h400, 32'haa, 0, 32'hbb, 0);
    cyc();
    set_disp(8, 32'h404, 32'hcc, 0, 32'hdd, 0);
    check("t4_second_tag", 32'(disp_tag), 32'd2);
    cyc();
    disp_valid = 1'b0;
    check("t4_iss_valid", 32'(iss_valid), 32'd1);
    repeat (3) begin
      cyc();
      check("t4_hold_valid", 32'(iss_valid), 32'd1);
      check("t4_hold_tag",   32'(iss_tag),   32'd1);
      check("t4_hold_op",    32'(iss_op),    32'd7);
      check("t4_hold_vj",    iss_vj,          32'haa);
      check("t4_hold_vk",    iss_vk,          32'hbb);
      check("t4_hold_occ",   32'(occupancy), 32'd1);
    end
    flush_in = 1'b1;
    set_disp(9, 32'h408, 32'd1, 0, 32'd1, 0);
    cyc();
    flush_in = 1'b0; disp_valid = 1'b0;
    check("t4_flush_valid", 32'(iss_valid),  32'd0);
    check("t4_flush_occ",   32'(occupancy),  32'd0);
    check("t4_flush_ready", 32'(disp_ready), 32'd1);
    iss_ready = 1'b1;
    cyc();
    check("t4_flush_nothing", 32'(iss_valid), 32'd0);

    // Issue order between an older higher-index and a younger lower-index entry.
    set_disp(10, 32'h500, 32'd0, 5, 32'd1, 0);
    cyc();
    set_disp(11, 32'h504, 32'd0, 6, 32'd2, 0);
    cyc();
    set_disp(12, 32'h508, 32'd0, 7, 32'd3, 0);
    cyc();
    disp_valid = 1'b0;
    set_cdb(5, 32'h55);
    sb.push_back(mk_exp(1, 10, 32'h55, 32'd1, 32'h500));
    cyc();
    cdb_active = 1'b0;
    cyc();
    check("t6_reuse_tag", 32'(disp_tag), 32'd1);
    set_disp(13, 32'h50c, 32'd0, 7, 32'd4, 0);
    cyc();
    disp_valid = 1'b0;
    set_cdb(7, 32'h77);
    cyc();
    cdb_active = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
    sb.push_back(mk_exp(3, 12, 32'h77, 32'd3, 32'h508));
    sb.push_back(mk_exp(1, 13, 32'h77, 32'd4, 32'h50c));
    cyc();
    check("t6_first_tag", 32'(iss_tag), 32'd3);
    cyc();
    check("t6_second_tag", 32'(iss_tag), 32'd1);
`else
    sb.push_back(mk_exp(1, 13, 32'h77, 32'd4, 32'h50c));
    sb.push_back(mk_exp(3, 12, 32'h77, 32'd3, 32'h508));
    cyc();
    check("t6_first_tag", 32'(iss_tag), 32'd1);
    cyc();
    check("t6_second_tag", 32'(iss_tag), 32'd3);
`endif
    set_cdb(6, 32'h66);
    sb.push_back(mk_exp(2, 11, 32'h66, 32'd2, 32'h504));
    cyc();
    cdb_active = 1'b0;
    repeat (3) cyc();
    check("t6_occ_end",   32'(occupancy), 32'd0);
    check("t6_valid_end", 32'(iss_valid), 32'd0);

    // Asynchronous reset with three busy entries.
    for (int i = 0; i < 3; i++) begin
      set_disp(20 + i, 32'h600 + 32'(4 * i), 32'd0, 9, 32'd0, 0);
      cyc();
    end
    disp_valid = 1'b0;
    check("t7_occ3", 32'(occupancy), 32'd3);
    rst_in = 1'b0;
    #1;
    check("t7_rst_valid", 32'(iss_valid),  32'd0);
    check("t7_rst_occ",   32'(occupancy),  32'd0);
    check("t7_rst_ready", 32'(disp_ready), 32'd1);
    check("t7_rst_tag",   32'(disp_tag),   32'd1);
    cyc();
    rst_in = 1'b1;
    cyc();
    check("t7_post_occ", 32'(occupancy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
